stopwatch_cu_lap: RTL and testbench

Parametrised control unit for the stopwatch datapath. It extends the run/stop/clear FSM with three additions: a lap (split) hold mode, a long-press clear that works while the stopwatch is running, and a multi-cycle clear pulse. It sits between the button debouncers (Btn_R, Btn_L, Btn_U) and the stopwatch datapath/display mux. It performs its own rising-edge detection on debounced button levels.

---
 rtl/stopwatch_cu_lap.sv | 152 +++++++++++++++
 tb/tb_stopwatch_cu_lap.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cu_lap.sv
// ---------------------------------------------------------------------------
// stopwatch_cu_lap
//
// Control unit for the stopwatch datapath. It implements a run/stop/clear FSM
// with three additions:
//   - a lap (split) hold mode that freezes the display while counting goes on,
//   - a long-press clear that is accepted while the stopwatch is running, and
//   - a clear pulse that lasts several cycles.
// Rising edges on the debounced button levels are detected inside this block.
//
// Parameters:
//   HOLD_CYCLES : number of consecutive high samples of i_clear that force a
//                 clear from RUN or LAP (must be >= 2)
//   CLR_CYCLES  : number of cycles o_clear stays high for each clear
//                 (must be >= 1)
//
// Ports:
//   clk        in   system clock; everything updates on the rising edge
//   rst        in   asynchronous reset, active low
//   i_runstop  in   debounced Btn_R level
//   i_clear    in   debounced Btn_L level
//   i_lap      in   debounced Btn_U level
//   o_runstop  out  datapath tick enable (RUN or LAP)
//   o_clear    out  datapath counter clear (CLEAR)
//   o_lap_hold out  display freeze (LAP)
//   o_state    out  current state code: 00 STOP, 01 RUN, 10 CLEAR, 11 LAP
// ---------------------------------------------------------------------------
module stopwatch_cu_lap #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CLR_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_runstop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_runstop,
  output logic       o_clear,
  output logic       o_lap_hold,
  output logic [1:0] o_state
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = $clog2(CLR_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          runstop_d;
  logic          clear_d;
  logic          lap_d;
  logic          rise_runstop;
  logic          rise_clear;
  logic          rise_lap;

  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] clr_cnt;
  logic          counting;
  logic          long_clr;
  logic          clear_done;

  // The delay flops reset to 1, so a button that is already held when reset
  // is released does not look like a fresh press.
  assign rise_runstop = i_runstop & ~runstop_d;
  assign rise_clear   = i_clear   & ~clear_d;
  assign rise_lap     = i_lap     & ~lap_d;

  assign counting   = (state == ST_RUN) || (state == ST_LAP);

  // Fires on the HOLD_CYCLES-th consecutive high sample. On the following
  // edge the FSM is already in CLEAR, which zeroes the hold counter, so one
  // press can trigger at most one clear.
  assign long_clr   = counting && i_clear && (hold_cnt == HOLD_LAST);

  assign clear_done = (clr_cnt == CLR_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (rise_runstop)    state_nxt = ST_RUN;
        else if (rise_clear) state_nxt = ST_CLEAR;
      end
      ST_RUN: begin
        if (long_clr)          state_nxt = ST_CLEAR;
        else if (rise_runstop) state_nxt = ST_STOP;
        else if (rise_lap)     state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (long_clr)          state_nxt = ST_CLEAR;
        else if (rise_runstop) state_nxt = ST_STOP;
        else if (rise_lap)     state_nxt = ST_RUN;
      end
      ST_CLEAR: begin
        // Buttons are ignored here; edges seen now are simply lost.
        if (clear_done) state_nxt = ST_STOP;
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  // Outputs are registered from the next state so that they change on the
  // same edge as the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_STOP;
      runstop_d  <= 1'b1;
      clear_d    <= 1'b1;
      lap_d      <= 1'b1;
      hold_cnt   <= '0;
      clr_cnt    <= '0;
      o_runstop  <= 1'b0;
      o_clear    <= 1'b0;
      o_lap_hold <= 1'b0;
      o_state    <= 2'b00;
    end else begin
      runstop_d <= i_runstop;
      clear_d   <= i_clear;
      lap_d     <= i_lap;

      if (counting && i_clear) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end

      if ((state_nxt == ST_CLEAR) && (state != ST_CLEAR)) begin
        clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + CW'(1);
      end

      state      <= state_nxt;
      o_runstop  <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
      o_clear    <= (state_nxt == ST_CLEAR);
      o_lap_hold <= (state_nxt == ST_LAP);
      o_state    <= state_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_cu_lap.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_cu_lap
//
// Directed bench for stopwatch_cu_lap with HOLD_CYCLES=8, CLR_CYCLES=3.
// Inputs change 1 time unit after a rising clock edge; outputs are observed
// 1 time unit after the next rising edge. Each observation compares the
// packed vector {o_state, o_runstop, o_clear, o_lap_hold} with a constant.
// ---------------------------------------------------------------------------
module tb_stopwatch_cu_lap;

  localparam int HOLD = 8;
  localparam int CLRC = 3;

  // {state[1:0], runstop, clear, lap_hold}
  localparam logic [4:0] O_STOP  = 5'b00_000;
  localparam logic [4:0] O_RUN   = 5'b01_100;
  localparam logic [4:0] O_CLEAR = 5'b10_010;
  localparam logic [4:0] O_LAP   = 5'b11_101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       runstop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       o_runstop;
  logic       o_clear;
  logic       o_lap_hold;
  logic [1:0] o_state;

  int checks = 0;
  int failures = 0;

  stopwatch_cu_lap #(
    .HOLD_CYCLES(HOLD),
    .CLR_CYCLES (CLRC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_runstop (runstop),
    .i_clear   (clear),
    .i_lap     (lap),
    .o_runstop (o_runstop),
    .o_clear   (o_clear),
    .o_lap_hold(o_lap_hold),
    .o_state   (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {o_state, o_runstop, o_clear, o_lap_hold};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press and release a button: the press edge is observed, then released.
  task automatic press_runstop(input string tag, input logic [4:0] exp);
    runstop = 1'b1; step(); check(tag, outs(), exp);
    runstop = 1'b0; step();
  endtask

  task automatic press_lap(input string tag, input logic [4:0] exp);
    lap = 1'b1; step(); check(tag, outs(), exp);
    lap = 1'b0; step();
  endtask

  // Observe the remaining CLEAR cycles after the entry edge, then STOP.
  task automatic finish_clear(input string tag);
    for (int i = 2; i <= CLRC; i++) begin
      step(); check({tag, "_clr_hold"}, outs(), O_CLEAR);
    end
    step(); check({tag, "_clr_end"}, outs(), O_STOP);
  endtask

  initial begin
    // 1. Reset, start, stop
    step(2);
    check("reset_outs", outs(), O_STOP);
    rst = 1'b1;
    step();
    check("post_reset", outs(), O_STOP);
    press_runstop("start", O_RUN);
    check("run_kept", outs(), O_RUN);
    press_runstop("stop", O_STOP);

    // 2. Clear from STOP, held button gives a single clear
    clear = 1'b1;
    step(); check("stop_clear_enter", outs(), O_CLEAR);
    finish_clear("stop_clear");
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (outs() != O_STOP) bad++;
      end
      check("held_clear_no_repeat", bad, 0);
    end
    clear = 1'b0; step();

    // 3. Lap mode
    press_runstop("lap_run", O_RUN);
    press_lap("lap_enter", O_LAP);
    check("lap_kept", outs(), O_LAP);
    press_lap("lap_exit", O_RUN);
    press_lap("lap_again", O_LAP);
    press_runstop("lap_stop", O_STOP);

    // 4a. Seven-cycle hold in RUN is a short press
    press_runstop("short_run", O_RUN);
    clear = 1'b1;
    begin
      int bad = 0;
      for (int i = 0; i < HOLD - 1; i++) begin
        step();
        if (outs() != O_RUN) bad++;
      end
      check("short_hold_no_clear", bad, 0);
    end
    clear = 1'b0; step();
    check("short_hold_still_run", outs(), O_RUN);

    // 4b. Eight-cycle hold in RUN forces a clear on the 8th edge
    clear = 1'b1;
    step(HOLD - 1);
    check("long_run_pre", outs(), O_RUN);
    step(); check("long_run_enter", outs(), O_CLEAR);
    clear = 1'b0;
    finish_clear("long_run");

    // 4c. Same from LAP
    press_runstop("long_lap_run", O_RUN);
    press_lap("long_lap_enter_lap", O_LAP);
    clear = 1'b1;
    step(HOLD - 1);
    check("long_lap_pre", outs(), O_LAP);
    step(); check("long_lap_enter", outs(), O_CLEAR);
    clear = 1'b0;
    finish_clear("long_lap");

    // 5a. Simultaneous runstop and lap in RUN: STOP wins
    press_runstop("simul_run", O_RUN);
    runstop = 1'b1; lap = 1'b1;
    step(); check("simul_stop_wins", outs(), O_STOP);
    runstop = 1'b0; lap = 1'b0; step();

    // 5b. Runstop on the long_clr edge: CLEAR wins
    press_runstop("prio_run", O_RUN);
    clear = 1'b1;
    step(HOLD - 1);
    runstop = 1'b1;
    step(); check("long_clr_beats_stop", outs(), O_CLEAR);
    runstop = 1'b0; clear = 1'b0;

    // 5c. Rises during CLEAR are ignored and lost
    step(); check("ign_clear_c2", outs(), O_CLEAR);
    runstop = 1'b1; lap = 1'b1; clear = 1'b1;
    step(); check("ign_clear_c3", outs(), O_CLEAR);
    step(); check("ign_clear_end", outs(), O_STOP);
    step(); check("ign_edges_lost", outs(), O_STOP);
    runstop = 1'b0; lap = 1'b0; clear = 1'b0; step();

    // Alternate-cycle toggling is honoured each time
    runstop = 1'b1; step(); check("toggle_run", outs(), O_RUN);
    runstop = 1'b0; step();
    runstop = 1'b1; step(); check("toggle_stop", outs(), O_STOP);
    runstop = 1'b0; step();

    // 6a. Button held through reset release
    rst = 1'b0; runstop = 1'b1;
    step();
    check("held_rst_in_reset", outs(), O_STOP);
    rst = 1'b1;
    step(2);
    check("held_rst_no_start", outs(), O_STOP);
    runstop = 1'b0; step();

    // 6b. Asynchronous reset in the 2nd cycle of CLEAR
    clear = 1'b1;
    step(); check("async_clear_c1", outs(), O_CLEAR);
    clear = 1'b0;
    step(); check("async_clear_c2", outs(), O_CLEAR);
    #2 rst = 1'b0;
    #1 check("async_rst_drop", outs(), O_STOP);
    step(2);
    check("async_rst_hold", outs(), O_STOP);
    @(negedge clk); rst = 1'b1;
    step(4);
    check("after_async_rst", outs(), O_STOP);
    press_runstop("after_rst_start", O_RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
